// File: rtl/icache_direct_mapped_pkg.sv
// icache_direct_mapped_pkg: shared bus opcodes, cache FSM states and geometry helpers for caches on the block controller
package icache_direct_mapped_pkg;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction
  function automatic int block_size(input int offset_w);
    return 1 << offset_w;
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: line word array (async read, sync write) plus per-line tag and valid registers with bulk clear
module icache_line_store
  import icache_direct_mapped_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_WIDTH = 3,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INDEX_WIDTH-1:0]        rd_index,
  input  logic [BLOCK_OFFSET_WIDTH-1:0] rd_offset,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [TAG_WIDTH-1:0]          rd_tag,
  output logic                          rd_valid,
  input  logic [INDEX_WIDTH-1:0]        line_index,
  input  logic                          wr_en,
  input  logic [BLOCK_OFFSET_WIDTH-1:0] wr_offset,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          tag_we,
  input  logic [TAG_WIDTH-1:0]          tag_data,
  input  logic                          set_valid,
  input  logic                          inv_en,
  input  logic                          clear_all
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = block_size(BLOCK_OFFSET_WIDTH);
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];
  logic [TAG_WIDTH-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  assign rd_data = data_q[rd_index][rd_offset];
  assign rd_tag = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  always_ff @(posedge clk) begin
    if (wr_en) data_q[line_index][wr_offset] <= wr_data;
    if (tag_we) tag_q[line_index] <= tag_data;
  end
  always_ff @(posedge clk) begin
    if (rst || clear_all) valid_q <= '0;
    else if (inv_en) valid_q[line_index] <= 1'b0;
    else if (set_valid) valid_q[line_index] <= 1'b1;
  end
endmodule

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only I-cache; zero-latency CPU hits (cpu_*), block refills over mem_* from the block controller, flush pulse
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hit,
  output logic                  cpu_stall,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req_op,
  output logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] mem_data_read,
  input  logic                  mem_data_read_valid,
  input  logic                  mem_finished
);
  localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_OFFSET_WIDTH);
  state_t state, state_next;
  logic [TAG_WIDTH-1:0] tag, rd_tag;
  logic [INDEX_WIDTH-1:0] index, miss_index, line_index;
  logic [BLOCK_OFFSET_WIDTH-1:0] offset, fill_cnt;
  logic fill_full, flush_pending, rd_valid, miss, beat, clear_all, set_valid;
  assign tag = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign index = cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
  assign offset = cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
  assign miss_index = mem_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
  assign mem_rw = READ;
  icache_line_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH),
    .BLOCK_OFFSET_WIDTH(BLOCK_OFFSET_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_store (
    .clk(clk),
    .rst(rst),
    .rd_index(index),
    .rd_offset(offset),
    .rd_data(cpu_rdata),
    .rd_tag(rd_tag),
    .rd_valid(rd_valid),
    .line_index(line_index),
    .wr_en(beat),
    .wr_offset(fill_cnt),
    .wr_data(mem_data_read),
    .tag_we(state == DONE),
    .tag_data(mem_addr[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .set_valid(set_valid),
    .inv_en(miss),
    .clear_all(clear_all)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // A flush seen during DONE itself is folded in so the freshly filled line never survives it.
  always_comb begin
    cpu_hit = cpu_req && state == IDLE && rd_valid && rd_tag == tag;
    cpu_stall = cpu_req && !cpu_hit;
    miss = cpu_req && state == IDLE && !cpu_hit;
    beat = state == FILL && mem_data_read_valid && !fill_full;
    mem_req_op = state == REQ;
    line_index = state == IDLE ? index : miss_index;
    clear_all = state == IDLE ? flush : state == DONE && (flush_pending || flush);
    set_valid = state == DONE && !(flush_pending || flush);
    state_next = state == IDLE ? (miss ? REQ : IDLE)
               : state == REQ  ? FILL
               : state == FILL ? (mem_finished ? DONE : FILL)
               : IDLE;
  end
  // The carry out of the offset counter becomes the full flag, so beats after the last word are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      {fill_full, fill_cnt} <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (miss) mem_addr <= {tag, index, {BLOCK_OFFSET_WIDTH{1'b0}}};
      if (state == REQ) {fill_full, fill_cnt} <= '0;
      else if (beat) {fill_full, fill_cnt} <= {fill_full, fill_cnt} + 1'b1;
      flush_pending <= state == DONE ? 1'b0 : (state != IDLE && flush) ? 1'b1 : flush_pending;
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: table-driven fetch vectors with scoreboard plus hand sequences for fill, flush and reset corners
module tb_icache_direct_mapped;
  logic clk = 0, rst = 1, cpu_req = 0, flush = 0;
  logic [15:0] cpu_addr = 0, mem_addr;
  logic [31:0] cpu_rdata, mem_data_read = 0;
  logic cpu_hit, cpu_stall, mem_req_op, mem_rw;
  logic mem_data_read_valid = 0, mem_finished = 0;
  int n_checks = 0, n_fail = 0, cyc = 0, req_count = 0, op_cycles = 0;
  int beat = -1, extra = 0, fin_cycle = 0, addr_drift = 0;
  logic [15:0] last_base = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int reqs;
    logic [15:0] base;
  } vec_t;
  vec_t tbl[9];
  icache_direct_mapped dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_stall(cpu_stall), .flush(flush),
    .mem_addr(mem_addr), .mem_req_op(mem_req_op), .mem_rw(mem_rw),
    .mem_data_read(mem_data_read), .mem_data_read_valid(mem_data_read_valid),
    .mem_finished(mem_finished)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_req_op) op_cycles <= op_cycles + 1;
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA000 + ((32'(a[15:5]) ^ 32'h91) << 8) + 32'(a[4:0]);
  endfunction
  function automatic vec_t mk(input logic [15:0] a, input int r);
    vec_t v;
    v.addr = a;
    v.data = mem_word(a);
    v.reqs = r;
    v.base = a & 16'hFFE0;
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // block controller model: 32 words per request, optional extra beats before finished, aborts on reset
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_op && !rst) begin
        req_count++;
        last_base = mem_addr;
        for (int i = 0; i < 32 + extra; i++) begin
          @(negedge clk);
          if (rst) break;
          if (mem_addr !== last_base) addr_drift++;
          beat = i;
          mem_data_read_valid = 1;
          mem_data_read = i < 32 ? mem_word(last_base + 16'(i)) : 32'hDEAD_0000 + 32'(i);
          mem_finished = i == 31 + extra;
          if (mem_finished) fin_cycle = cyc;
        end
        if (!rst) @(negedge clk);
        mem_data_read_valid = 0;
        mem_finished = 0;
        beat = -1;
      end
    end
  end
  task automatic fetch(input logic [15:0] a, input logic [31:0] exp, output int reqs, output int hit_cyc);
    int r0, n;
    logic [31:0] e;
    r0 = req_count;
    sb.push_back(exp);
    @(negedge clk);
    cpu_req = 1;
    cpu_addr = a;
    #1;
    n = 0;
    while (!cpu_hit && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    hit_cyc = cyc;
    reqs = req_count - r0;
    e = sb.pop_front();
    check($sformatf("hit_%h", a), 32'(cpu_hit), 1);
    check($sformatf("rdata_%h", a), cpu_rdata, e);
    cpu_req = 0;
  endtask
  task automatic wait_beat(input int b);
    int n = 0;
    #1;
    while (beat != b && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("reach_beat_%0d", b), 32'(beat), 32'(b));
  endtask
  initial begin
    int reqs, hc, r0;
    tbl[0] = mk(16'h123F, 0);
    tbl[1] = mk(16'h1220, 0);
    tbl[2] = mk(16'h5234, 1);
    tbl[3] = mk(16'h1234, 1);
    tbl[4] = mk(16'h0040, 1);
    tbl[5] = mk(16'h005F, 0);
    tbl[6] = mk(16'h1230, 0);
    tbl[7] = mk(16'hFFFF, 1);
    tbl[8] = mk(16'hFFE0, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("reset_hit", 32'(cpu_hit), 0);
    check("reset_stall_idle", 32'(cpu_stall), 0);
    check("reset_req_op", 32'(mem_req_op), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("mem_rw", 32'(mem_rw), 0);
    cpu_req = 1;
    cpu_addr = 16'h1234;
    #1;
    check("reset_miss_hit", 32'(cpu_hit), 0);
    check("reset_miss_stall", 32'(cpu_stall), 1);
    cpu_req = 0;
    fetch(16'h1234, 32'h0000_A014, reqs, hc);
    check("cold_reqs", 32'(reqs), 1);
    check("cold_base", 32'(last_base), 32'h1220);
    check("cold_latency", 32'(hc - fin_cycle), 2);
    check("cold_pulse", 32'(op_cycles), 1);
    for (int i = 0; i < 9; i++) begin
      fetch(tbl[i].addr, tbl[i].data, reqs, hc);
      check($sformatf("reqs_%h", tbl[i].addr), 32'(reqs), 32'(tbl[i].reqs));
      if (tbl[i].reqs == 1) check($sformatf("base_%h", tbl[i].addr), 32'(last_base), 32'(tbl[i].base));
    end
    extra = 2;
    fetch(16'h2000, mem_word(16'h2000), reqs, hc);
    extra = 0;
    check("extra_reqs", 32'(reqs), 1);
    fetch(16'h2001, mem_word(16'h2001), reqs, hc);
    check("extra_no_refill", 32'(reqs), 0);
    fetch(16'h201F, mem_word(16'h201F), reqs, hc);
    r0 = req_count;
    sb.push_back(mem_word(16'h3040));
    @(negedge clk);
    cpu_req = 1;
    cpu_addr = 16'h3040;
    wait_beat(10);
    flush = 1;
    @(negedge clk);
    #1;
    flush = 0;
    fetch(16'h3040, sb.pop_front(), reqs, hc);
    check("flush_fill_refetch", 32'(req_count - r0), 2);
    @(negedge clk);
    cpu_req = 1;
    cpu_addr = 16'h3040;
    flush = 1;
    #1;
    check("flush_same_cycle_hit", 32'(cpu_hit), 1);
    check("flush_same_cycle_data", cpu_rdata, mem_word(16'h3040));
    @(negedge clk);
    flush = 0;
    #1;
    check("flush_idle_invalid", 32'(cpu_hit), 0);
    cpu_req = 0;
    fetch(16'hFFE0, mem_word(16'hFFE0), reqs, hc);
    check("flush_all_lines", 32'(reqs), 1);
    @(negedge clk);
    cpu_req = 1;
    cpu_addr = 16'h4080;
    wait_beat(5);
    rst = 1;
    cpu_req = 0;
    @(negedge clk);
    #1;
    rst = 0;
    check("rst_mid_req_op", 32'(mem_req_op), 0);
    check("rst_mid_mem_addr", 32'(mem_addr), 0);
    cpu_req = 1;
    cpu_addr = 16'hFFE0;
    #1;
    check("rst_mid_invalid", 32'(cpu_hit), 0);
    cpu_req = 0;
    r0 = req_count;
    fetch(16'h4080, mem_word(16'h4080), reqs, hc);
    check("rst_refetch", 32'(reqs), 1);
    fetch(16'h4085, mem_word(16'h4085), reqs, hc);
    check("rst_refetch_word5", 32'(reqs), 0);
    check("pulse_width", 32'(op_cycles), 32'(req_count));
    check("addr_stable", 32'(addr_drift), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache; it is the initiator (cache side) of the block-transfer memory controller protocol.
- Serves single-word CPU fetches from an on-chip line store.
- On a miss it issues one block-read request and captures 2^BLOCK_OFFSET_WIDTH words streamed back by the controller.
- Sits between the CPU fetch stage and the BRAM block controller.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 16, word address width (1 word per address).
- BLOCK_OFFSET_WIDTH, 5, log2 of words per line (32 words).
- INDEX_WIDTH, 3, log2 of line count (8 lines). TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-BLOCK_OFFSET_WIDTH = 8.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  fetch request, held until cpu_hit
- cpu_addr  in  ADDR_WIDTH  word address {tag, index, offset}; stable while cpu_req is high
- cpu_rdata  out  DATA_WIDTH  fetched word, valid when cpu_hit=1
- cpu_hit  out  1  combinational: cpu_req && state==IDLE && valid[index] && tag match
- cpu_stall  out  1  cpu_req && !cpu_hit
- flush  in  1  one-cycle pulse; invalidate all lines
- mem_addr  out  ADDR_WIDTH  block base {tag, index, 0}
- mem_req_op  out  1  one-cycle start pulse
- mem_rw  out  1  constant 0 (read)
- mem_data_read  in  DATA_WIDTH  streamed word
- mem_data_read_valid  in  1  qualifies mem_data_read
- mem_finished  in  1  block transfer complete

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; all valid bits=0; mem_req_op=0; mem_addr=0; fill_cnt=0; flush_pending=0.
  - cpu_rdata is don't-care; cpu_hit=0 follows from valid=0.
  - Tag and data arrays are not reset.
  - Reset mid-fill abandons the fill; the line stays invalid. The controller is reset by the same system reset.
- IDLE:
  - On a hit, cpu_rdata = data[index][offset] in the same cycle (zero-latency hit).
  - On a miss (cpu_req && !hit): latch mem_addr={tag,index,0} and miss_index, clear valid[miss_index], go to REQ.
- REQ (1 cycle): mem_req_op=1; go to FILL; clear fill_cnt.
- FILL:
  - mem_req_op=0; mem_addr held stable.
  - Each cycle with mem_data_read_valid && !fill_full: write data[miss_index][fill_cnt] and increment fill_cnt.
  - fill_full is set when fill_cnt wraps from 31; extra valid beats are ignored.
  - When mem_finished=1: capture the beat in that same cycle if valid and not full, then go to DONE.
- DONE (1 cycle): write tag[miss_index]; set valid[miss_index]=1 unless flush_pending; go to IDLE.
  - DONE also covers the controller's post-finish wait cycle, so it is back in READY before any new mem_req_op.
- Write priority: the data word written in the mem_finished cycle must be readable as a hit in the first IDLE cycle.
- Flush:
  - In IDLE, all valid bits clear at the next edge; a same-cycle hit is still returned.
  - In REQ, FILL or DONE, set flush_pending; in DONE, clear all valid bits (including the filled line) and flush_pending.
  - flush and rst together: reset wins.
- Miss on a line whose tag differs replaces it (no write-back; read-only).
- cpu_addr change while stalled is a protocol violation; behaviour is undefined.
- Width rules:
  - fill_cnt is BLOCK_OFFSET_WIDTH bits plus a 1-bit full flag.
  - index and offset are plain bit slices of cpu_addr.

Decomposition:
- Shared package:
  - localparams READ=0, WRITE=1.
  - State encodings IDLE/REQ/FILL/DONE (2-bit).
  - TAG_WIDTH and BLOCK_SIZE derivations, reusable by a future data cache on the same controller.
- One sub-module, icache_line_store: 2^INDEX_WIDTH x 2^BLOCK_OFFSET_WIDTH word array, one async read port and one sync write port, plus tag/valid registers with bulk clear.

Test Plan:
- Cold miss: rst, then cpu_req addr 0x1234 → mem_req_op pulses once with mem_addr=0x1220, mem_rw=0. Model returns 32 words 0xA000+i, finished on the 32nd beat. cpu_hit rises 2 cycles after finished with cpu_rdata=0xA014.
- Hit-after-fill: same line, addr 0x123F → cpu_hit same cycle, cpu_rdata=0xA01F, no mem_req_op.
- Conflict: addr 0x5234 (same index 1, tag 0x52) → refill with mem_addr=0x5220. A following fetch of 0x1234 misses again.
- Extra valid beats: model holds data_read_valid for 2 cycles after the 32nd word → words 0..31 unchanged, line valid, fill_cnt ignores the extras.
- Flush mid-fill: pulse flush during beat 10 of a fill → after DONE the line is invalid, and a re-fetch issues a new mem_req_op.
- Reset mid-fill: rst at beat 5 → state IDLE, mem_req_op=0, all misses. A following fetch re-requests the block.
